// File: rtl/axis_frame_tx.sv
`timescale 1ns/1ps
// axis_frame_tx: groups an incoming byte stream into frames of
// header byte, PLD_LEN payload bytes, then an additive checksum beat that
// carries tlast. Both sides use AXI4-Stream handshakes. The output is a
// single register stage, and that stage can be refilled on the same cycle
// that it drains.
module axis_frame_tx #(
   parameter int                   DATA_WDTH = 8,
   parameter int                   PLD_LEN   = 4,
   parameter logic [DATA_WDTH-1:0] HDR_BYTE  = 'hA5
) (
   input  logic                 m_axis_clk,
   input  logic                 m_axis_aresetn,
   input  logic [DATA_WDTH-1:0] s_axis_tdata,
   input  logic                 s_axis_tvalid,
   output logic                 s_axis_tready,
   output logic [DATA_WDTH-1:0] m_axis_tdata,
   output logic                 m_axis_tvalid,
   input  logic                 m_axis_tready,
   output logic                 m_axis_tlast,
   output logic [15:0]          frame_cnt
);

   localparam int             CNT_W    = $clog2(PLD_LEN + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PLD_LEN - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_PAYLOAD,
      S_CSUM
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [DATA_WDTH-1:0] r_tdata;
   logic                 r_tvalid;
   logic                 r_tlast;
   logic [DATA_WDTH-1:0] r_sum;
   logic [CNT_W-1:0]     r_cnt;
   logic [15:0]          r_frame_cnt;

   logic                 w_free;
   logic                 w_s_tready;
   logic                 w_load;
   logic [DATA_WDTH-1:0] w_load_data;
   logic                 w_load_last;
   logic [DATA_WDTH-1:0] w_sum_nxt;
   logic [CNT_W-1:0]     w_cnt_nxt;

   // The output register can take a new beat when it is empty or being drained.
   assign w_free = !r_tvalid || m_axis_tready;

   // Next-state logic and the decision whether to load the output register.
   // NOTE: every signal gets a default first, so that no path infers a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_s_tready  = 1'b0;
      w_load      = 1'b0;
      w_load_data = r_tdata;
      w_load_last = 1'b0;
      w_sum_nxt   = r_sum;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         S_IDLE: begin
            // A header goes out only once payload is waiting; the byte itself stays put.
            if (s_axis_tvalid && w_free) begin
               w_load      = 1'b1;
               w_load_data = HDR_BYTE;
               w_sum_nxt   = '0;
               w_cnt_nxt   = '0;
               w_state_nxt = S_PAYLOAD;
            end
         end
         S_PAYLOAD: begin
            w_s_tready = w_free;
            if (s_axis_tvalid && w_free) begin
               w_load      = 1'b1;
               w_load_data = s_axis_tdata;
               w_sum_nxt   = r_sum + s_axis_tdata;
               w_cnt_nxt   = r_cnt + CNT_W'(1);
               if (r_cnt == CNT_LAST) begin
                  w_state_nxt = S_CSUM;
               end
            end
         end
         S_CSUM: begin
            if (w_free) begin
               w_load      = 1'b1;
               w_load_data = r_sum;
               w_load_last = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State register.
   // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge m_axis_clk or negedge m_axis_aresetn) begin
      if (!m_axis_aresetn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Output stage: it loads a new beat, drops valid when the beat is taken
   // and nothing replaces it, and otherwise holds its contents.
   always_ff @(posedge m_axis_clk or negedge m_axis_aresetn) begin
      if (!m_axis_aresetn) begin
         r_tvalid <= 1'b0;
         r_tdata  <= '0;
         r_tlast  <= 1'b0;
      end else if (w_load) begin
         r_tvalid <= 1'b1;
         r_tdata  <= w_load_data;
         r_tlast  <= w_load_last;
      end else if (m_axis_tready) begin
         r_tvalid <= 1'b0;
         r_tlast  <= 1'b0;
      end
   end

   // Running checksum and payload counter for the frame in progress.
   always_ff @(posedge m_axis_clk or negedge m_axis_aresetn) begin
      if (!m_axis_aresetn) begin
         r_sum <= '0;
         r_cnt <= '0;
      end else begin
         r_sum <= w_sum_nxt;
         r_cnt <= w_cnt_nxt;
      end
   end

   // Count a frame when its checksum beat is handed downstream.
   always_ff @(posedge m_axis_clk or negedge m_axis_aresetn) begin
      if (!m_axis_aresetn) begin
         r_frame_cnt <= '0;
      end else if (r_tvalid && m_axis_tready && r_tlast) begin
         r_frame_cnt <= r_frame_cnt + 16'd1;
      end
   end

   assign s_axis_tready = w_s_tready;
   assign m_axis_tdata  = r_tdata;
   assign m_axis_tvalid = r_tvalid;
   assign m_axis_tlast  = r_tlast;
   assign frame_cnt     = r_frame_cnt;

endmodule

// File: doc/axis_frame_tx.md
# axis_frame_tx

Downstream framing stage for the `axi4_str_fifo` master (read) port, clocked in the `m_axis_clk` domain. It consumes the FIFO's byte stream and groups every `PLD_LEN` bytes into a frame. Each frame is emitted on an AXI4-Stream master with a header byte first, then the payload, then a modulo-2^`DATA_WDTH` checksum marked with `tlast`. Full AXIS backpressure is honoured on both sides, and outputs are registered.

## Interface
Parameters:
- `DATA_WDTH`, 8, byte width of both streams.
- `PLD_LEN`, 4, payload bytes per frame; legal range 1..255.
- `HDR_BYTE`, 'hA5, constant header value.

Ports:
- `m_axis_clk`  in  1  single clock for the block.
- `m_axis_aresetn`  in  1  reset, asynchronous, active low.
- `s_axis_tdata`  in  DATA_WDTH  byte from FIFO `m_axis_tdata`.
- `s_axis_tvalid`  in  1  FIFO data valid.
- `s_axis_tready`  out  1  block accepts byte.
- `m_axis_tdata`  out  DATA_WDTH  framed output byte.
- `m_axis_tvalid`  out  1  output valid.
- `m_axis_tready`  in  1  downstream ready.
- `m_axis_tlast`  out  1  high on the checksum beat only.
- `frame_cnt`  out  16  completed frames, wraps at 2^16.

## Operation
- Output register: a single stage holds `m_axis_tdata`, `m_axis_tvalid` and `m_axis_tlast`.
  - `free = !m_axis_tvalid || m_axis_tready`.
  - Once `m_axis_tvalid` is high, the register holds tdata and tlast stable until the beat is accepted (`m_axis_tvalid && m_axis_tready`).
- FSM states: IDLE, PAYLOAD, CSUM.
  - **IDLE**: if `s_axis_tvalid && free`, load `HDR_BYTE` with tlast=0, clear `sum` and `cnt`, and go to PAYLOAD. The input byte is not consumed in this cycle. A frame starts only when data is available.
  - **PAYLOAD**: `s_axis_tready = free`. On input accept:
    - load `s_axis_tdata` into the output register;
    - `sum <= sum + s_axis_tdata`, truncated to `DATA_WDTH`;
    - `cnt <= cnt + 1`.
    - When the accept is the `PLD_LEN`-th byte (`cnt == PLD_LEN-1`), go to CSUM.
  - **CSUM**: `s_axis_tready = 0`. If `free`, load `sum` with tlast=1 and go to IDLE.
- `s_axis_tready` is 0 in IDLE and CSUM. It is combinational from state and `free`.
- `frame_cnt` increments when a beat with `m_axis_tlast=1` is accepted.
- Input gaps (`s_axis_tvalid` low) mid-frame stall the frame. No timeout; the frame is never truncated.

## Timing
- Reset values: state=IDLE, `m_axis_tvalid`=0, `m_axis_tdata`=0, `m_axis_tlast`=0, `frame_cnt`=0, `sum`=0, `cnt`=0.
  - `s_axis_tready` is 0 during reset (it is derived from state).
- Latency: a byte accepted in cycle t appears on `m_axis_tdata` in cycle t+1.
- Throughput with `s_axis_tvalid` and `m_axis_tready` constantly high: one beat per cycle and `PLD_LEN+2` cycles per frame. Frames are back to back with no idle output cycle.
- Backpressure:
  - When `m_axis_tready`=0 while `m_axis_tvalid`=1, `s_axis_tready` is 0 in the same cycle and no state advances.
  - When `m_axis_tready` returns to 1, transfer resumes that cycle.
- Simultaneous events: output accept and a new load in the same cycle are legal; the register is overwritten with no bubble.
- Reset mid-frame: asynchronous assertion clears everything immediately, so `m_axis_tvalid` drops without waiting for a clock.
  - The partial frame is discarded; no checksum or tlast is emitted.
  - After release, the next frame starts fresh from the header.
- `PLD_LEN=1`: PAYLOAD lasts exactly one accepted byte, and the checksum equals that byte.
- `sum` wraps modulo 2^`DATA_WDTH`. `cnt` width is `$clog2(PLD_LEN+1)`.

## Test plan
- **Basic frame** (defaults, `m_axis_tready`=1): input BA, DA, FA, 55 → output A5, BA, DA, FA, 55, E3.
  - tlast is high only on E3.
  - `frame_cnt` becomes 1.
  - Output starts 1 cycle after the first `s_axis_tvalid`.
- **Back to back**: 8 bytes 01..08 with continuous valid → frames A5 01 02 03 04 0A and A5 05 06 07 08 1A.
  - 12 consecutive valid beats with no gap.
  - `frame_cnt`=2.
- **Backpressure**: toggle `m_axis_tready` 1,0,0,1 repeatedly during the basic frame.
  - The output sequence is identical to the basic frame.
  - Data is held stable while stalled.
  - `s_axis_tready` is never high while the output is stalled.
- **Input gaps**: insert 5 idle cycles between BA and DA.
  - The output stalls after BA, and the frame completes with checksum E3.
  - No extra beats are emitted.
- **Reset mid-frame**: assert reset after A5, BA have been accepted.
  - `m_axis_tvalid`=0 and `frame_cnt`=0 immediately.
  - After release, input 11, 22, 33, 44 → A5, 11, 22, 33, 44, AA.
- **Single-byte frame** (`PLD_LEN`=1): input FF → A5, FF, FF with tlast on the third beat; repeated input FF gives continuous 3-beat frames.
